// File: rtl/gnt_bus_sequencer_pkg.sv
// Shared types and defaults for the grant-driven bus sequencer.
// Holds the FSM state encoding, owner encoding and default bus widths.
package gnt_bus_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam logic OWNER_0 = 1'b0;
    localparam logic OWNER_1 = 1'b1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/gnt_bus_sequencer_timeout_ctr.sv
// Bus-wait counter: counts REQ cycles without ack and flags the last allowed cycle.
// The limit forces the FSM out of REQ, so the count saturates instead of wrapping.
module xfer_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/gnt_bus_sequencer.sv
// Latches the granted requester's command, runs one bus transaction with
// ack/timeout, and returns a done/err pulse plus captured read data.
module gnt_bus_sequencer
    import gnt_bus_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic              wr_0,
    input  logic              wr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_re,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              done_0,
    output logic              done_1,
    output logic              err_0,
    output logic              err_1,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_parity,
    output logic              gnt_err,
    output logic              busy
);

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    seq_state_e        state_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              bus_re_q;
    logic              bus_we_q;
    logic              done0_q;
    logic              done1_q;
    logic              err0_q;
    logic              err1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              par_q;
    logic              gnt_err_q;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              tmo_expired;

    // Grant 1 selects port 1; only meaningful when exactly one grant is high.
    always_comb begin
        sel_wr    = gnt_1 ? wr_1    : wr_0;
        sel_addr  = gnt_1 ? addr_1  : addr_0;
        sel_wdata = gnt_1 ? wdata_1 : wdata_0;
    end

    xfer_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == ST_IDLE),
        .en_i      ((state_q == ST_REQ) && !bus_ack),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            bus_re_q  <= 1'b0;
            bus_we_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata_q   <= '0;
            par_q     <= 1'b0;
            gnt_err_q <= 1'b0;
        end else begin
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            gnt_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_0 && gnt_1) begin
                        gnt_err_q <= 1'b1;
                    end else if (gnt_0 || gnt_1) begin
                        owner_q  <= gnt_1 ? OWNER_1 : OWNER_0;
                        addr_q   <= sel_addr;
                        wr_q     <= sel_wr;
                        wdata_q  <= sel_wdata;
                        bus_re_q <= ~sel_wr;
                        bus_we_q <= sel_wr;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over an expiring counter in the same cycle.
                    if (bus_ack || tmo_expired) begin
                        bus_re_q <= 1'b0;
                        bus_we_q <= 1'b0;
                        done0_q  <= (owner_q == OWNER_0);
                        done1_q  <= (owner_q == OWNER_1);
                        err0_q   <= !bus_ack && (owner_q == OWNER_0);
                        err1_q   <= !bus_ack && (owner_q == OWNER_1);
                        if (bus_ack && !wr_q) begin
                            rdata_q <= bus_rdata;
                            par_q   <= parity_of(bus_rdata);
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign bus_re       = bus_re_q;
    assign bus_we       = bus_we_q;
    assign done_0       = done0_q;
    assign done_1       = done1_q;
    assign err_0        = err0_q;
    assign err_1        = err1_q;
    assign rdata        = rdata_q;
    assign rdata_parity = par_q;
    assign gnt_err      = gnt_err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gnt_bus_sequencer.sv
// Bench for gnt_bus_sequencer: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_gnt_bus_sequencer;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          gnt_0 = 1'b0, gnt_1 = 1'b0;
    logic [AW-1:0] addr_0 = '0, addr_1 = '0;
    logic          wr_0 = 1'b0, wr_1 = 1'b0;
    logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
    logic [AW-1:0] bus_addr;
    logic          bus_re, bus_we;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;
    logic          done_0, done_1, err_0, err_1;
    logic [DW-1:0] rdata;
    logic          rdata_parity, gnt_err, busy;

    always #5 clk = ~clk;

    gnt_bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .addr_0(addr_0), .addr_1(addr_1),
        .wr_0(wr_0), .wr_1(wr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .done_0(done_0), .done_1(done_1), .err_0(err_0), .err_1(err_1),
        .rdata(rdata), .rdata_parity(rdata_parity),
        .gnt_err(gnt_err), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a command occupies the bus for some number of
    // cycles, then reports for one cycle, then the port is free again.
    bit            m_valid = 0;
    int            m_phase = 0;   // 0 free, 1 on bus, 2 reporting
    int            m_used  = 0;   // bus cycles consumed by current command
    bit            m_owner;
    logic [AW-1:0] m_addr  = '0;
    bit            m_wr;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            e_re, e_we, e_done0, e_done1, e_err0, e_err1, e_gerr;

    always @(posedge clk) begin
        m_valid = 1;
        e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0; e_gerr = 0;
        if (!reset) begin
            m_phase = 0; m_used = 0; m_owner = 0; m_addr = '0; m_wr = 0;
            m_wdata = '0; m_rdata = '0; e_re = 0; e_we = 0;
        end else if (m_phase == 0) begin
            if (gnt_0 && gnt_1) e_gerr = 1;
            else if (gnt_0 || gnt_1) begin
                m_owner = gnt_1;
                m_addr  = gnt_1 ? addr_1 : addr_0;
                m_wr    = gnt_1 ? wr_1 : wr_0;
                m_wdata = gnt_1 ? wdata_1 : wdata_0;
                m_used  = 0;
                m_phase = 1;
                e_re = !m_wr; e_we = m_wr;
            end
        end else if (m_phase == 1) begin
            m_used++;
            if (bus_ack || m_used == TMO) begin
                if (bus_ack && !m_wr) m_rdata = bus_rdata;
                e_done0 = !m_owner;            e_done1 = m_owner;
                e_err0  = !bus_ack && !m_owner; e_err1  = !bus_ack && m_owner;
                e_re = 0; e_we = 0;
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("bus_re", bus_re, e_re);
            chk("bus_we", bus_we, e_we);
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_wdata", bus_wdata, m_wdata);
            chk("done_0", done_0, e_done0);
            chk("done_1", done_1, e_done1);
            chk("err_0", err_0, e_err0);
            chk("err_1", err_1, e_err1);
            chk("rdata", rdata, m_rdata);
            chk("rdata_parity", rdata_parity, $countones(m_rdata) % 2);
            chk("gnt_err", gnt_err, e_gerr);
            chk("busy", busy, m_phase != 0);
        end
    end

    initial begin
        int n;
        bit got;
        bit er;
        int nd;
        int dpos[$];

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_bus_re", bus_re, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus_addr", bus_addr, 0);
        reset = 1'b1;

        // Read via port 0, ack on the third bus cycle
        gnt_0 = 1; addr_0 = 8'hA5; wr_0 = 0;
        @(negedge clk); gnt_0 = 0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus_re && bus_addr == 8'hA5) n++;
            if (i == 2) begin bus_ack = 1; bus_rdata = 32'h0000_0007; end
            @(negedge clk);
        end
        bus_ack = 0;
        chk("rd_re_cycles", n, 3);
        chk("rd_done0", done_0, 1);
        chk("rd_err0", err_0, 0);
        chk("rd_rdata", rdata, 32'h7);
        chk("rd_parity", rdata_parity, 1);
        @(negedge clk);

        // Write via port 1, immediate ack
        gnt_1 = 1; addr_1 = 8'h3C; wr_1 = 1; wdata_1 = 32'hDEAD_BEEF;
        @(negedge clk); gnt_1 = 0;
        chk("wr_we", bus_we, 1);
        chk("wr_re", bus_re, 0);
        chk("wr_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("wr_addr", bus_addr, 8'h3C);
        bus_ack = 1;
        @(negedge clk); bus_ack = 0;
        chk("wr_done1", done_1, 1);
        chk("wr_done0", done_0, 0);
        chk("wr_we_off", bus_we, 0);
        chk("wr_rdata_hold", rdata, 32'h7);
        @(negedge clk);

        // Timeout with no ack
        gnt_0 = 1; addr_0 = 8'h11; wr_0 = 0;
        @(negedge clk); gnt_0 = 0;
        n = 0; got = 0; er = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_0) begin got = 1; er = err_0; break; end
            if (bus_re) n++;
            @(negedge clk);
        end
        chk("to_re_cycles", n, TMO);
        chk("to_done", got, 1);
        chk("to_err", er, 1);
        chk("to_rdata_hold", rdata, 32'h7);
        @(negedge clk);

        // Ack on the last allowed cycle wins over timeout
        gnt_0 = 1; addr_0 = 8'h22;
        @(negedge clk); gnt_0 = 0;
        for (int i = 0; i < TMO; i++) begin
            if (i == TMO - 1) begin bus_ack = 1; bus_rdata = 32'h0000_0003; end
            @(negedge clk);
        end
        bus_ack = 0;
        chk("lim_done0", done_0, 1);
        chk("lim_err0", err_0, 0);
        chk("lim_rdata", rdata, 32'h3);
        chk("lim_parity", rdata_parity, 0);
        @(negedge clk);

        // Both grants in idle
        gnt_0 = 1; gnt_1 = 1;
        @(negedge clk); gnt_0 = 0; gnt_1 = 0;
        chk("both_gnt_err", gnt_err, 1);
        chk("both_busy", busy, 0);
        chk("both_re", bus_re, 0);
        chk("both_we", bus_we, 0);
        @(negedge clk);
        chk("both_gnt_err_off", gnt_err, 0);
        chk("both_nodone", done_0 | done_1, 0);

        // Reset on the second bus cycle
        gnt_0 = 1; addr_0 = 8'h55; wr_0 = 0;
        @(negedge clk); gnt_0 = 0;
        @(negedge clk); reset = 0;
        @(negedge clk);
        chk("mrst_re", bus_re, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_rdata", rdata, 0);
        chk("mrst_done", done_0, 0);
        reset = 1;
        @(negedge clk);
        chk("mrst_nodone", done_0, 0);
        gnt_1 = 1; addr_1 = 8'h3C; wr_1 = 1; wdata_1 = 32'h1234;
        @(negedge clk); gnt_1 = 0; bus_ack = 1;
        @(negedge clk); bus_ack = 0;
        chk("mrst_fresh_done1", done_1, 1);
        @(negedge clk);

        // Back-to-back with grant and ack held high
        gnt_0 = 1; wr_0 = 1; bus_ack = 1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus_we) chk("b2b_addr", bus_addr, AW'(i - 1));
            addr_0 = AW'(i);
            if (done_0) begin nd++; dpos.push_back(i); end
            @(negedge clk);
        end
        gnt_0 = 0; bus_ack = 0;
        chk("b2b_count", nd, 5);
        if (dpos.size() >= 2) chk("b2b_spacing", dpos[1] - dpos[0], 3);
        @(negedge clk);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            gnt_0     = ($urandom % 3) == 0;
            gnt_1     = ($urandom % 3) == 0;
            addr_0    = AW'($urandom);
            addr_1    = AW'($urandom);
            wr_0      = $urandom % 2;
            wr_1      = $urandom % 2;
            wdata_0   = $urandom;
            wdata_1   = $urandom;
            bus_ack   = ($urandom % 4) == 0;
            bus_rdata = $urandom;
            reset     = ($urandom % 100) != 0;
            @(negedge clk);
        end
        reset = 1; gnt_0 = 0; gnt_1 = 0; bus_ack = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
